// File: rtl/apb_cfg_master.sv
// APB3 initiator: accepts one local command at a time, runs a SETUP/ACCESS
// transfer with optional wait-state timeout, and holds the result on a response channel.
module apb_cfg_master #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_write_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  rsp_timeout_o,
  output logic [ADDR_WIDTH-1:0] paddr_o,
  output logic [DATA_WIDTH-1:0] pwdata_o,
  output logic                  psel_o,
  output logic                  penable_o,
  output logic                  pwrite_o,
  input  logic                  pready_i,
  input  logic [DATA_WIDTH-1:0] prdata_i,
  input  logic                  pslverr_i,
  output logic                  busy_o
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_next;
  logic             timeout_hit;

  assign cmd_ready_o = (state == IDLE);
  assign busy_o      = (state != IDLE);

  // The count includes the current low-pready cycle, so the abort lands on the limit cycle.
  assign wait_next   = wait_cnt + 1'b1;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_next == CNT_W'(TIMEOUT_CYCLES));

  // NOTE: every state and output register is cleared by the async reset, so an
  // in-flight transfer vanishes without a response; non-blocking assignments
  // keep all registers updating from the same pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      paddr_o       <= '0;
      pwdata_o      <= '0;
      pwrite_o      <= 1'b0;
      psel_o        <= 1'b0;
      penable_o     <= 1'b0;
      rsp_valid_o   <= 1'b0;
      rsp_rdata_o   <= '0;
      rsp_err_o     <= 1'b0;
      rsp_timeout_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid_i) begin
            paddr_o   <= cmd_addr_i;
            pwrite_o  <= cmd_write_i;
            pwdata_o  <= cmd_write_i ? cmd_wdata_i : '0;
            psel_o    <= 1'b1;
            penable_o <= 1'b0;
            wait_cnt  <= '0;
            state     <= SETUP;
          end
        end
        SETUP: begin
          penable_o <= 1'b1;
          state     <= ACCESS;
        end
        ACCESS: begin
          if (pready_i) begin
            rsp_rdata_o   <= pwrite_o ? '0 : prdata_i;
            rsp_err_o     <= pslverr_i;
            rsp_timeout_o <= 1'b0;
            rsp_valid_o   <= 1'b1;
            psel_o        <= 1'b0;
            penable_o     <= 1'b0;
            state         <= RESP;
          end else begin
            wait_cnt <= wait_next;
            if (timeout_hit) begin
              rsp_rdata_o   <= '0;
              rsp_err_o     <= 1'b1;
              rsp_timeout_o <= 1'b1;
              rsp_valid_o   <= 1'b1;
              psel_o        <= 1'b0;
              penable_o     <= 1'b0;
              state         <= RESP;
            end
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/apb_cfg_master.md
Name: apb_cfg_master

Overview:
APB3 initiator that turns single-beat commands from a local valid/ready interface into APB transfers. It sits between the VGA boot/config sequencer (or a debug bridge) and the APB-attached VGA config registers, which hold base address, offset, self-test enable, resolution select and the four resolution table entries. It returns read data, slave error and a local timeout indication on a response channel.

Parameters:
DATA_WIDTH, 32, width of APB write/read data and of the command/response data.
ADDR_WIDTH, 32, width of the APB address and of the command address.
TIMEOUT_CYCLES, 16, maximum number of ACCESS-phase cycles to wait for pready_i; 0 disables the timeout.

Ports:
clk  input  1  clock
resetn  input  1  asynchronous active-low reset
cmd_valid_i  input  1  command present
cmd_ready_o  output  1  command accepted when cmd_valid_i is also high
cmd_write_i  input  1  1 = write, 0 = read
cmd_addr_i  input  ADDR_WIDTH  target register address (word index)
cmd_wdata_i  input  DATA_WIDTH  write data; ignored for reads
rsp_valid_o  output  1  response present
rsp_ready_i  input  1  response consumed
rsp_rdata_o  output  DATA_WIDTH  read data (0 for writes and for timeouts)
rsp_err_o  output  1  pslverr_i sampled at completion, or timeout
rsp_timeout_o  output  1  transfer aborted by timeout
paddr_o  output  ADDR_WIDTH  APB address
pwdata_o  output  DATA_WIDTH  APB write data
psel_o  output  1  APB select
penable_o  output  1  APB enable
pwrite_o  output  1  APB direction
pready_i  input  1  APB ready
prdata_i  input  DATA_WIDTH  APB read data
pslverr_i  input  1  APB slave error
busy_o  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, resetn low): state goes to IDLE immediately, and all outputs go to 0, including paddr_o, pwdata_o, pwrite_o, the rsp_* outputs and the timeout counter. A transfer in flight is dropped without a response. The first clk edge after resetn rises is a normal IDLE cycle.
- FSM states are IDLE, SETUP, ACCESS and RESP. All outputs are registered except cmd_ready_o = (state==IDLE) and busy_o = (state!=IDLE).
- IDLE: on cmd_valid_i && cmd_ready_o, latch write/addr/wdata into paddr_o, pwrite_o and pwdata_o (pwdata_o = 0 for reads). Next state is SETUP.
- SETUP, one cycle: psel_o=1, penable_o=0. Next state is ACCESS.
- ACCESS: psel_o=1, penable_o=1. paddr_o, pwdata_o and pwrite_o stay stable from SETUP until the transfer ends.
  - pready_i sampled high: the transfer completes. Capture rsp_rdata_o = pwrite_o ? 0 : prdata_i, rsp_err_o = pslverr_i, rsp_timeout_o = 0. Drive psel_o and penable_o to 0 and go to RESP.
  - pready_i low: increment the wait counter. If TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES, abort: psel_o=0, penable_o=0, rsp_err_o=1, rsp_timeout_o=1, rsp_rdata_o=0, and go to RESP.
  - The counter clears on entry to SETUP. If pready_i is sampled high in the same cycle the counter reaches its limit, completion wins.
- RESP: rsp_valid_o=1, and rsp_* stay stable until rsp_valid_o && rsp_ready_i. After that handshake, rsp_valid_o=0 and the next state is IDLE.
- No pipelining: at most one transfer is outstanding. cmd_ready_o is low from SETUP through RESP.
- Minimum latency from command accept edge to rsp_valid_o high is 3 cycles with a zero-wait slave. The config register slave asserts pready one cycle into ACCESS, so that case is 4 cycles. The minimum command-to-command period is 4 cycles with a zero-wait slave and rsp_ready_i tied high.
- Address and data are passed through unmodified; the block does no decoding. An out-of-range address is the slave's concern, and an unmapped register write completes with pslverr as returned.
- psel_o never drops between SETUP and completion, and penable_o is never high without psel_o.

Test Plan:
- Zero-wait write: cmd addr=0x0, wdata=0x8000_0000. Expect one SETUP cycle, then ACCESS with pready high, then rsp_valid=1 with err=0 and timeout=0. paddr_o/pwdata_o must be stable across SETUP and ACCESS, and the slave base register must read 0x8000_0000.
- Config-register sequence: write 0x1=0x0004_B000, write 0x4=0x1234_5678, write 0x5=0x0000_00AB, then read 0x4. Expect rdata 0x1234_5678 and each response 4 cycles after accept.
- Wait states and error: slave holds pready low for 5 ACCESS cycles, then returns pready=1, pslverr=1, prdata=0xDEAD_BEEF on a read. Expect rsp_err=1, rdata=0xDEAD_BEEF, timeout=0.
- Timeout: TIMEOUT_CYCLES=16 and pready held low. Expect psel dropped after 16 ACCESS cycles, then rsp_err=1, rsp_timeout=1, rdata=0, and the FSM back in IDLE after rsp_ready. Also check the limit cycle with pready=1, which must complete normally.
- Response backpressure: hold rsp_ready_i low for 10 cycles. Expect rsp_* stable, cmd_ready_o=0, and a new cmd_valid ignored until the handshake.
- Async reset mid-ACCESS: deassert resetn asynchronously between edges. Expect psel/penable/rsp_valid to go to 0 immediately and no response. After release, a new write 0x2=0x1 completes normally.
